// File: rtl/t_flip_flop.sv
// rtl/t_flip_flop.sv - bank of independent toggle flip-flops with complementary outputs.
// Optional saturating toggle-event counter when TFF_TOGGLE_CNT_EN is defined.
module t_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
`ifdef TFF_TOGGLE_CNT_EN
  output logic [WIDTH-1:0] qn,
  output logic [CNT_W-1:0] toggle_cnt
`else
  output logic [WIDTH-1:0] qn
`endif
);

  logic [WIDTH-1:0] r_q;

  // XOR with t lets an X/Z toggle enable corrupt only the affected bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= r_q ^ t;
    end
  end

  assign q  = r_q;
  assign qn = ~r_q;

`ifdef TFF_TOGGLE_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_any_toggle;
  logic             w_cnt_full;

  assign w_any_toggle = |t;
  assign w_cnt_full   = &r_cnt;

  // One increment per edge with any toggle, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_any_toggle && !w_cnt_full) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign toggle_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_t_flip_flop.sv
// tb/tb_t_flip_flop.sv - directed self-checking bench for t_flip_flop (1-bit and 4-bit instances).
module tb_t_flip_flop;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       t1 = 1'b0;
  logic [3:0] t4 = 4'b0000;
  logic       q1, qn1;
  logic [3:0] q4, qn4;
`ifdef TFF_TOGGLE_CNT_EN
  logic [1:0] cnt1_unused;
  logic [1:0] cnt4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  t_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0), .CNT_W(2)) u_tff1 (
    .clk(clk), .reset(reset), .t(t1), .q(q1),
`ifdef TFF_TOGGLE_CNT_EN
    .qn(qn1), .toggle_cnt(cnt1_unused)
`else
    .qn(qn1)
`endif
  );

  t_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b0000), .CNT_W(2)) u_tff4 (
    .clk(clk), .reset(reset), .t(t4), .q(q4),
`ifdef TFF_TOGGLE_CNT_EN
    .qn(qn4), .toggle_cnt(cnt4)
`else
    .qn(qn4)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    t1 = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (q1 !== 1'b0 || qn1 !== 1'b1) begin
        errors++;
        $display("FAIL reset_w1 edge%0d: got q=%b qn=%b exp q=0 qn=1", i, q1, qn1);
      end
      checks++;
      if (q4 !== 4'b0000 || qn4 !== 4'b1111) begin
        errors++;
        $display("FAIL reset_w4 edge%0d: got q=%b qn=%b exp q=0000 qn=1111", i, q4, qn4);
      end
    end
  endtask

  task automatic test_hold();
    reset = 1'b1;
    t1 = 1'b0;
    step();
    checks++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      errors++;
      $display("FAIL hold: got q=%b qn=%b exp q=0 qn=1", q1, qn1);
    end
  endtask

  task automatic test_toggle();
    t1 = 1'b1;
    step();
    checks++;
    if (q1 !== 1'b1 || qn1 !== 1'b0) begin
      errors++;
      $display("FAIL toggle_up: got q=%b qn=%b exp q=1 qn=0", q1, qn1);
    end
    t1 = 1'b0;
    step();
    checks++;
    if (q1 !== 1'b1 || qn1 !== 1'b0) begin
      errors++;
      $display("FAIL toggle_hold: got q=%b qn=%b exp q=1 qn=0", q1, qn1);
    end
    t1 = 1'b1;
    step();
    checks++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      errors++;
      $display("FAIL toggle_down: got q=%b qn=%b exp q=0 qn=1", q1, qn1);
    end
  endtask

  task automatic test_divide();
    logic [3:0] exp_seq;
    exp_seq = 4'b1010;
    t1 = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      step();
      checks++;
      if (q1 !== exp_seq[i] || qn1 !== ~exp_seq[i]) begin
        errors++;
        $display("FAIL divide edge%0d: got q=%b qn=%b exp q=%b", 3 - i, q1, qn1, exp_seq[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    t1 = 1'b1;
    step();
    checks++;
    if (q1 !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got q=%b exp q=1", q1);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      errors++;
      $display("FAIL async_immediate: got q=%b qn=%b exp q=0 qn=1", q1, qn1);
    end
    step();
    checks++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      errors++;
      $display("FAIL async_held: got q=%b qn=%b exp q=0 qn=1", q1, qn1);
    end
    t1 = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_multibit();
    logic [3:0] exp_q [3];
    exp_q[0] = 4'b1010;
    exp_q[1] = 4'b0000;
    exp_q[2] = 4'b1010;
    t4 = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q4 !== exp_q[i] || qn4 !== ~exp_q[i]) begin
        errors++;
        $display("FAIL multibit edge%0d: got q=%b qn=%b exp q=%b qn=%b", i, q4, qn4, exp_q[i], ~exp_q[i]);
      end
    end
    t4 = 4'b0110;
    step();
    checks++;
    if (q4 !== 4'b1100 || qn4 !== 4'b0011) begin
      errors++;
      $display("FAIL multibit_mixed: got q=%b qn=%b exp q=1100 qn=0011", q4, qn4);
    end
    t4 = 4'b0000;
  endtask

  task automatic test_t_between_edges();
    #2;
    t4 = 4'b1111;
    #2;
    t4 = 4'b0000;
    step();
    checks++;
    if (q4 !== 4'b1100) begin
      errors++;
      $display("FAIL t_glitch: got q=%b exp q=1100", q4);
    end
  endtask

`ifdef TFF_TOGGLE_CNT_EN
  task automatic test_counter();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1;
    exp_cnt[1] = 2'd2;
    exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3;
    exp_cnt[4] = 2'd3;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    checks++;
    if (cnt4 !== 2'd0) begin
      errors++;
      $display("FAIL cnt_reset: got %0d exp 0", cnt4);
    end
    t4 = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (cnt4 !== exp_cnt[i]) begin
        errors++;
        $display("FAIL cnt_edge%0d: got %0d exp %0d", i, cnt4, exp_cnt[i]);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (cnt4 !== 2'd0) begin
      errors++;
      $display("FAIL cnt_async_clear: got %0d exp 0", cnt4);
    end
    t4 = 4'b0000;
    reset = 1'b1;
    t4 = 4'b0001;
    step();
    checks++;
    if (cnt4 !== 2'd1) begin
      errors++;
      $display("FAIL cnt_restart: got %0d exp 1", cnt4);
    end
    t4 = 4'b0000;
    step();
    checks++;
    if (cnt4 !== 2'd1) begin
      errors++;
      $display("FAIL cnt_idle: got %0d exp 1", cnt4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hold();
    test_toggle();
    test_divide();
    test_async_reset();
    test_multibit();
    test_t_between_edges();
`ifdef TFF_TOGGLE_CNT_EN
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
